// File: rtl/rtc_write_sequencer_if.sv
// rtl/rtc_write_sequencer_if.sv - multiplexed address/data bus toward the RTC chip
interface rtc_write_sequencer_if;
    logic       cs_n;
    logic       a_d_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        output cs_n,
        output a_d_n,
        output wr_n,
        output rd_n,
        output ad_out,
        output ad_oe
    );

    modport slave (
        input cs_n,
        input a_d_n,
        input wr_n,
        input rd_n,
        input ad_out,
        input ad_oe
    );
endinterface

// File: rtl/rtc_write_sequencer.sv
// rtl/rtc_write_sequencer.sv - writes nine BCD time/date/timer fields plus a transfer command to the RTC
module rtc_write_sequencer #(
    parameter int         PHASE_CYC = 4,
    parameter logic [7:0] CMD_ADDR  = 8'hF0,
    parameter logic [7:0] CMD_DATA  = 8'hF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8:0]            field_en,
    input  logic [7:0]            seg_C,
    input  logic [7:0]            min_C,
    input  logic [7:0]            hora_C,
    input  logic [7:0]            dia,
    input  logic [7:0]            mes,
    input  logic [7:0]            ano,
    input  logic [7:0]            seg_T,
    input  logic [7:0]            min_T,
    input  logic [7:0]            hora_T,
    output logic                  busy,
    output logic                  done,
    rtc_write_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_STROBE,
        S_A_HOLD,
        S_D_SETUP,
        S_D_STROBE,
        S_D_HOLD,
        S_GAP
    } state_t;

    // Index 9 selects the trailing transfer command rather than a field.
    localparam logic [3:0] CMD_IDX = 4'd9;
    localparam logic [3:0] PH_LAST = 4'(PHASE_CYC - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] phase_cnt;
    logic       ph_last;
    logic [3:0] cur_idx;
    logic [8:0] rem;
    logic       done_q;
    logic [7:0] snap [0:8];

    logic [8:0] enc_in;
    logic [8:0] enc_onehot;
    logic [3:0] enc_idx;
    logic [7:0] cur_addr;
    logic [7:0] cur_data;

    logic       cs_n_c;
    logic       a_d_n_c;
    logic       wr_n_c;
    logic [7:0] ad_out_c;
    logic       ad_oe_c;

    // Values above 99 cannot be shown on two BCD digits, so they pin at 99.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        if (v > 8'd99) begin
            return 8'h99;
        end
        return ((v / 8'd10) << 4) | (v % 8'd10);
    endfunction

    assign ph_last = (phase_cnt == PH_LAST);

    // Lowest pending field: from the live mask when launching, else from what is left of the snapshot.
    always_comb begin
        enc_in     = (state == S_IDLE) ? field_en : rem;
        enc_onehot = enc_in & (~enc_in + 9'd1);
        enc_idx    = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (enc_in[i]) begin
                enc_idx = 4'(i);
            end
        end
    end

    // State register; async reset drops the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase sequencing; the GAP exit either chains the next transaction or returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start && (field_en != 9'd0)) state_next = S_A_SETUP;
            S_A_SETUP:  if (ph_last) state_next = S_A_STROBE;
            S_A_STROBE: if (ph_last) state_next = S_A_HOLD;
            S_A_HOLD:   if (ph_last) state_next = S_D_SETUP;
            S_D_SETUP:  if (ph_last) state_next = S_D_STROBE;
            S_D_STROBE: if (ph_last) state_next = S_D_HOLD;
            S_D_HOLD:   if (ph_last) state_next = S_GAP;
            S_GAP:      if (ph_last) state_next = (cur_idx == CMD_IDX) ? S_IDLE : S_A_SETUP;
            default:    state_next = S_IDLE;
        endcase
    end

    // Snapshot capture, field selection, phase timing and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= 4'd0;
            cur_idx   <= 4'd0;
            rem       <= 9'd0;
            done_q    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                snap[i] <= 8'd0;
            end
        end else begin
            done_q    <= 1'b0;
            phase_cnt <= (state_next != state) ? 4'd0 : phase_cnt + 4'd1;
            if (state == S_IDLE && start) begin
                snap[0] <= to_bcd(seg_C);
                snap[1] <= to_bcd(min_C);
                snap[2] <= to_bcd(hora_C);
                snap[3] <= to_bcd(dia);
                snap[4] <= to_bcd(mes);
                snap[5] <= to_bcd(ano);
                snap[6] <= to_bcd(seg_T);
                snap[7] <= to_bcd(min_T);
                snap[8] <= to_bcd(hora_T);
                if (field_en == 9'd0) begin
                    done_q <= 1'b1;
                end else begin
                    cur_idx <= enc_idx;
                    rem     <= enc_in & ~enc_onehot;
                end
            end
            if (state == S_GAP && ph_last) begin
                if (cur_idx == CMD_IDX) begin
                    done_q <= 1'b1;
                end else if (rem != 9'd0) begin
                    cur_idx <= enc_idx;
                    rem     <= enc_in & ~enc_onehot;
                end else begin
                    cur_idx <= CMD_IDX;
                end
            end
        end
    end

    // Register address and BCD byte of the transaction in flight.
    always_comb begin
        cur_addr = CMD_ADDR;
        cur_data = CMD_DATA;
        case (cur_idx)
            4'd0: begin cur_addr = 8'h21; cur_data = snap[0]; end
            4'd1: begin cur_addr = 8'h22; cur_data = snap[1]; end
            4'd2: begin cur_addr = 8'h23; cur_data = snap[2]; end
            4'd3: begin cur_addr = 8'h24; cur_data = snap[3]; end
            4'd4: begin cur_addr = 8'h25; cur_data = snap[4]; end
            4'd5: begin cur_addr = 8'h26; cur_data = snap[5]; end
            4'd6: begin cur_addr = 8'h41; cur_data = snap[6]; end
            4'd7: begin cur_addr = 8'h42; cur_data = snap[7]; end
            4'd8: begin cur_addr = 8'h43; cur_data = snap[8]; end
            default: begin cur_addr = CMD_ADDR; cur_data = CMD_DATA; end
        endcase
    end

    // Bus pins decoded from the phase; bus value changes only in SETUP phases so wr_n never falls with it.
    always_comb begin
        cs_n_c   = 1'b1;
        a_d_n_c  = 1'b1;
        wr_n_c   = 1'b1;
        ad_out_c = 8'd0;
        ad_oe_c  = 1'b0;
        case (state)
            S_A_SETUP, S_A_HOLD: begin
                cs_n_c = 1'b0; a_d_n_c = 1'b0; ad_oe_c = 1'b1; ad_out_c = cur_addr;
            end
            S_A_STROBE: begin
                cs_n_c = 1'b0; a_d_n_c = 1'b0; ad_oe_c = 1'b1; ad_out_c = cur_addr; wr_n_c = 1'b0;
            end
            S_D_SETUP, S_D_HOLD: begin
                cs_n_c = 1'b0; ad_oe_c = 1'b1; ad_out_c = cur_data;
            end
            S_D_STROBE: begin
                cs_n_c = 1'b0; ad_oe_c = 1'b1; ad_out_c = cur_data; wr_n_c = 1'b0;
            end
            default: begin
                cs_n_c = 1'b1;
            end
        endcase
    end

    assign bus.cs_n   = cs_n_c;
    assign bus.a_d_n  = a_d_n_c;
    assign bus.wr_n   = wr_n_c;
    assign bus.rd_n   = 1'b1;
    assign bus.ad_out = ad_out_c;
    assign bus.ad_oe  = ad_oe_c;
    assign busy       = (state != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// tb/tb_rtc_write_sequencer.sv - directed vector bench for rtc_write_sequencer
module tb_rtc_write_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] field_en = 9'd0;
    logic [7:0] seg_C = 8'd0, min_C = 8'd0, hora_C = 8'd0, dia = 8'd0, mes = 8'd0;
    logic [7:0] ano = 8'd0, seg_T = 8'd0, min_T = 8'd0, hora_T = 8'd0;
    logic       busy;
    logic       done;

    rtc_write_sequencer_if bus ();

    rtc_write_sequencer #(
        .PHASE_CYC(4),
        .CMD_ADDR (8'hF0),
        .CMD_DATA (8'hF0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .field_en(field_en),
        .seg_C   (seg_C),
        .min_C   (min_C),
        .hora_C  (hora_C),
        .dia     (dia),
        .mes     (mes),
        .ano     (ano),
        .seg_T   (seg_T),
        .min_T   (min_T),
        .hora_T  (hora_T),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]       en;
        logic [8:0][7:0]  vals;
        logic [9:0][15:0] exp;
        logic [3:0]       n;
        logic [15:0]      busy_cyc;
    } vec_t;

    vec_t vecs [4];

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] s_val [$];
    logic       s_adn [$];
    int         s_len [$];
    int         busy_cnt = 0, done_cnt = 0, cs_low_cnt = 0, rd_low_cnt = 0, order_viol = 0;
    logic       prev_wr = 1'b1, prev_adn = 1'b1, cur_adn = 1'b1;
    logic [7:0] prev_ad = 8'd0, cur_val = 8'd0;
    int         wlen = 0;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (!bus.cs_n) cs_low_cnt++;
        if (!bus.rd_n) rd_low_cnt++;
        if (!bus.wr_n && prev_wr) begin
            if (bus.a_d_n !== prev_adn || bus.ad_out !== prev_ad) order_viol++;
            cur_val = bus.ad_out;
            cur_adn = bus.a_d_n;
            wlen = 1;
        end else if (!bus.wr_n) begin
            wlen++;
        end else if (!prev_wr) begin
            s_val.push_back(cur_val);
            s_adn.push_back(cur_adn);
            s_len.push_back(wlen);
        end
        prev_wr  = bus.wr_n;
        prev_adn = bus.a_d_n;
        prev_ad  = bus.ad_out;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic set_vals(input logic [8:0][7:0] v);
        seg_C = v[0]; min_C = v[1]; hora_C = v[2]; dia = v[3]; mes = v[4];
        ano = v[5]; seg_T = v[6]; min_T = v[7]; hora_T = v[8];
    endtask

    task automatic clear_mon();
        s_val.delete(); s_adn.delete(); s_len.delete();
        busy_cnt = 0; done_cnt = 0; cs_low_cnt = 0; rd_low_cnt = 0; order_viol = 0;
    endtask

    task automatic launch(input logic [8:0] en, input logic [8:0][7:0] v);
        #1;
        clear_mon();
        field_en = en;
        set_vals(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic ok);
        ok = 1'b0;
        lat = -1;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                lat = c;
            end
        end
    endtask

    task automatic verify(input int i, input string tag);
        int bad_len;
        int idx;
        check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(vecs[i].busy_cyc));
        check({tag, " cs_low_cycles"}, 32'(cs_low_cnt), 32'(vecs[i].n) * 32'd24);
        check({tag, " rd_n_low"}, 32'(rd_low_cnt), 32'd0);
        check({tag, " wr_fall_with_change"}, 32'(order_viol), 32'd0);
        check({tag, " strobe_count"}, 32'(s_val.size()), 32'(vecs[i].n) * 32'd2);
        for (int k = 0; k < int'(vecs[i].n); k++) begin
            idx = 2 * k;
            check($sformatf("%s addr%0d", tag, k),
                  (idx < s_val.size()) ? {23'd0, s_adn[idx], s_val[idx]} : 32'hFFFF,
                  {24'd0, vecs[i].exp[k][15:8]});
            check($sformatf("%s data%0d", tag, k),
                  (idx + 1 < s_val.size()) ? {23'd0, s_adn[idx+1], s_val[idx+1]} : 32'hFFFF,
                  {23'd0, 1'b1, vecs[i].exp[k][7:0]});
        end
        bad_len = 0;
        foreach (s_len[j]) if (s_len[j] != 4) bad_len++;
        check({tag, " strobe_width_not_4"}, 32'(bad_len), 32'd0);
    endtask

    int            lat;
    logic          ok;
    logic          found;
    logic [8:0][7:0] pert;

    initial begin
        for (int i = 0; i < 4; i++) vecs[i] = '0;

        vecs[0].en = 9'h001;
        for (int j = 0; j < 9; j++) vecs[0].vals[j] = 8'd7;
        vecs[0].vals[0] = 8'd45;
        vecs[0].exp[0] = 16'h2145; vecs[0].exp[1] = 16'hF0F0;
        vecs[0].n = 4'd2; vecs[0].busy_cyc = 16'd56;

        vecs[1].en = 9'h1FF;
        vecs[1].vals[0] = 8'd59; vecs[1].vals[1] = 8'd30; vecs[1].vals[2] = 8'd12;
        vecs[1].vals[3] = 8'd31; vecs[1].vals[4] = 8'd12; vecs[1].vals[5] = 8'd99;
        vecs[1].vals[6] = 8'd5;  vecs[1].vals[7] = 8'd0;  vecs[1].vals[8] = 8'd23;
        vecs[1].exp[0] = 16'h2159; vecs[1].exp[1] = 16'h2230; vecs[1].exp[2] = 16'h2312;
        vecs[1].exp[3] = 16'h2431; vecs[1].exp[4] = 16'h2512; vecs[1].exp[5] = 16'h2699;
        vecs[1].exp[6] = 16'h4105; vecs[1].exp[7] = 16'h4200; vecs[1].exp[8] = 16'h4323;
        vecs[1].exp[9] = 16'hF0F0;
        vecs[1].n = 4'd10; vecs[1].busy_cyc = 16'd280;

        vecs[2].en = 9'h120;
        for (int j = 0; j < 9; j++) vecs[2].vals[j] = 8'd33;
        vecs[2].vals[5] = 8'd150; vecs[2].vals[8] = 8'd7;
        vecs[2].exp[0] = 16'h2699; vecs[2].exp[1] = 16'h4307; vecs[2].exp[2] = 16'hF0F0;
        vecs[2].n = 4'd3; vecs[2].busy_cyc = 16'd84;

        vecs[3].en = 9'h082;
        for (int j = 0; j < 9; j++) vecs[3].vals[j] = 8'd64;
        vecs[3].vals[1] = 8'd100; vecs[3].vals[7] = 8'd9;
        vecs[3].exp[0] = 16'h2299; vecs[3].exp[1] = 16'h4209; vecs[3].exp[2] = 16'hF0F0;
        vecs[3].n = 4'd3; vecs[3].busy_cyc = 16'd84;

        // reset state
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst cs_n", 32'(bus.cs_n), 32'd1);
        check("rst a_d_n", 32'(bus.a_d_n), 32'd1);
        check("rst wr_n", 32'(bus.wr_n), 32'd1);
        check("rst rd_n", 32'(bus.rd_n), 32'd1);
        check("rst ad_out", 32'(bus.ad_out), 32'd0);
        check("rst ad_oe", 32'(bus.ad_oe), 32'd0);
        #1 reset = 1'b0;

        // table vectors
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            launch(vecs[i].en, vecs[i].vals);
            wait_done(lat, ok);
            check($sformatf("v%0d done_seen", i), 32'(ok), 32'd1);
            check($sformatf("v%0d done_latency", i), 32'(lat), 32'(vecs[i].busy_cyc));
            repeat (2) @(negedge clk);
            verify(i, $sformatf("v%0d", i));
        end

        // inputs change and start pulses mid-burst: snapshot must win
        @(negedge clk);
        launch(vecs[0].en, vecs[0].vals);
        repeat (10) @(negedge clk);
        for (int j = 0; j < 9; j++) pert[j] = 8'h11;
        field_en = 9'h1FF;
        set_vals(pert);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, ok);
        check("pert done_seen", 32'(ok), 32'd1);
        check("pert done_latency", 32'(lat), 32'd46);
        repeat (2) @(negedge clk);
        verify(0, "pert");

        // empty mask, then a start in its done cycle
        @(negedge clk);
        launch(9'd0, vecs[0].vals);
        wait_done(lat, ok);
        check("zero done_seen", 32'(ok), 32'd1);
        check("zero done_latency", 32'(lat), 32'd0);
        check("zero busy_cycles", 32'(busy_cnt), 32'd0);
        check("zero cs_low", 32'(cs_low_cnt), 32'd0);
        check("zero strobes", 32'(s_val.size()), 32'd0);
        launch(vecs[0].en, vecs[0].vals);
        wait_done(lat, ok);
        check("chain done_seen", 32'(ok), 32'd1);
        check("chain done_latency", 32'(lat), 32'd56);
        repeat (2) @(negedge clk);
        verify(0, "chain");

        // a second start in the done cycle of a nonzero burst
        launch(vecs[2].en, vecs[2].vals);
        wait_done(lat, ok);
        launch(vecs[3].en, vecs[3].vals);
        wait_done(lat, ok);
        check("chain2 done_latency", 32'(lat), 32'd84);
        repeat (2) @(negedge clk);
        verify(3, "chain2");

        // async reset during a data strobe
        @(negedge clk);
        launch(vecs[1].en, vecs[1].vals);
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (bus.a_d_n && !bus.wr_n && !bus.cs_n) found = 1'b1;
        end
        check("midrst reached_d_strobe", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst cs_n", 32'(bus.cs_n), 32'd1);
        check("midrst wr_n", 32'(bus.wr_n), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ad_oe", 32'(bus.ad_oe), 32'd0);
        check("midrst rd_n", 32'(bus.rd_n), 32'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        clear_mon();
        repeat (60) @(negedge clk);
        check("midrst no_done", 32'(done_cnt), 32'd0);
        check("midrst no_cs", 32'(cs_low_cnt), 32'd0);
        check("midrst no_busy", 32'(busy_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rtc_write_sequencer.md
Name: rtc_write_sequencer

Overview:
- Downstream consumer of the time/date/timer entry stage; takes the nine edited fields (clock seconds/minutes/hours, day, month, year, timer seconds/minutes/hours) as binary values.
- Converts each field to packed BCD and writes it into the external RTC chip over its multiplexed address/data bus.
- Issues a trailing transfer command so the chip latches the new values.
- A start pulse from the top-level controller launches one burst; busy and done report progress.

Parameters:
- PHASE_CYC, 4, clk cycles each bus phase is held (1..15)
- CMD_ADDR, 8'hF0, register address of the transfer command
- CMD_DATA, 8'hF0, data byte written as the transfer command

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to begin a write burst
- field_en  in  9  per-field write enable; bit0 seg_C ... bit8 hora_T, order below
- seg_C, min_C, hora_C, dia, mes, ano, seg_T, min_T, hora_T  in  8 each  binary field values
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at end of burst
- cs_n  out  1  chip select, active low
- a_d_n  out  1  0 = address phase, 1 = data phase
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe, held 1 always
- ad_out  out  8  bus value driven
- ad_oe  out  1  bus output enable (tristate drive in top level)

Behaviour:
- Reset (async): busy=0, done=0, cs_n=1, a_d_n=1, wr_n=1, rd_n=1, ad_out=0, ad_oe=0; FSM to IDLE; snapshot registers cleared. Reset mid-burst aborts immediately. There is no resume.
- Field order and register address (fixed): seg_C 21h, min_C 22h, hora_C 23h, dia 24h, mes 25h, ano 26h, seg_T 41h, min_T 42h, hora_T 43h.
- start is accepted only in IDLE; start while busy is ignored.
- On an accepted start, all nine values and field_en are captured in that same cycle. Input changes during the burst have no effect.
- BCD conversion on the captured value v:
  - v <= 99: byte = {tens, ones}.
  - v > 99: saturate to 8'h99.
- Zero mask: start with field_en=0 gives no bus activity, busy stays 0, and done pulses the cycle after start.
- Nonzero mask: busy=1 from the cycle after start.
  - Enabled fields are written in ascending bit order; disabled fields take zero cycles.
  - After the last field, one command transaction (CMD_ADDR, CMD_DATA) follows.
- Transaction FSM, 7 phases of PHASE_CYC cycles each, phase counter 4 bits:
  - A_SETUP: cs_n=0, a_d_n=0, ad_oe=1, ad_out=addr, wr_n=1
  - A_STROBE: as A_SETUP with wr_n=0
  - A_HOLD: wr_n=1, addr held
  - D_SETUP: a_d_n=1, ad_out=data
  - D_STROBE: wr_n=0
  - D_HOLD: wr_n=1, data held
  - GAP: cs_n=1, ad_oe=0, a_d_n=1, ad_out=0
- wr_n never falls in the same cycle that a_d_n or ad_out changes.
- Each transaction is 7*PHASE_CYC cycles. The first A_SETUP cycle is the cycle after start.
- Next-field search happens within the final GAP cycle, so transactions are back to back with no extra idle cycles.
- After the command transaction's last GAP cycle:
  - the next cycle has busy=0 and done=1 for one cycle;
  - the FSM is back in IDLE, and start is accepted in that done cycle.
- rd_n is constant 1 in every state.

Test Plan:
- Reset with PHASE_CYC=4: all outputs at reset values, rd_n=1. Assert reset during a D_STROBE: cs_n=1 and wr_n=1 asynchronously, busy=0, no done pulse.
- start with field_en=9'h001, seg_C=45: address 21h then data 45h, then command F0h/F0h. busy high 56 cycles, done 1 cycle later, exactly two wr_n pulses per transaction, each 4 cycles wide.
- field_en=9'h1FF with values 59, 30, 12, 31, 12, 99, 5, 0, 23: bytes 59h, 30h, 12h, 31h, 12h, 99h, 05h, 00h, 23h, then F0h, at addresses 21h-26h, 41h-43h, F0h. Total busy 280 cycles.
- field_en=9'h120 with ano=150: only ano (26h, data 99h saturated), hora_T (43h), and the command are written, in that order.
- Change inputs mid-burst and pulse start while busy: written bytes match the start-cycle snapshot, and the second start is ignored.
- field_en=0: no cs_n activity, done pulses the cycle after start. A start during the done cycle of a prior burst is accepted.
